alu_share_ctrl: RTL

//  Shares one registered ALU datapath (input regs -> ALU -> output/flag regs, 2-cycle latency)

---
 rtl/alu_share_pkg.sv | 19 +
 rtl/alu_share_rr_arb2.sv | 35 +++
 rtl/alu_share_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_share_pkg.sv
// Shared types and constants for the ALU sharing controller slice.
package alu_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Bit positions of the flags inside resp_flags = {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Latency of the registered ALU datapath this block is paired with
    localparam int DEFAULT_LAT = 2;

endpackage

// File: rtl/alu_share_rr_arb2.sv
// Two-way round-robin arbiter: the pointer side wins when it is valid,
// otherwise the other side is granted. Pointer moves away from the winner.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       accept,
    input  logic       id,
    output logic [1:0] grant
);

    logic pointer;

    // After an accepted grant the other requester gets priority next time
    always_ff @(posedge clk) begin
        if (!reset) begin
            pointer <= 1'b0;
        end else if (accept) begin
            pointer <= ~id;
        end
    end

    // Grant the preferred side first, fall back to the other one
    always_comb begin
        grant = 2'b00;
        if (pointer == 1'b0) begin
            if (valid[0])      grant = 2'b01;
            else if (valid[1]) grant = 2'b10;
        end else begin
            if (valid[1])      grant = 2'b10;
            else if (valid[0]) grant = 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one registered ALU datapath between two requesters. One op is in
// flight at a time: accept, present operands for LAT cycles, capture the
// result and flags, then hold them on the response channel until taken.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int n   = 2,
    parameter int LAT = DEFAULT_LAT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [n-1:0] req0_a,
    input  logic [n-1:0] req0_b,
    input  logic [3:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [n-1:0] req1_a,
    input  logic [n-1:0] req1_b,
    input  logic [3:0]   req1_op,
    output logic [n-1:0] dp_a,
    output logic [n-1:0] dp_b,
    output logic [3:0]   dp_op,
    input  logic [n-1:0] dp_result,
    input  logic         dp_N,
    input  logic         dp_Z,
    input  logic         dp_C,
    input  logic         dp_V,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [n-1:0] resp_result,
    output logic [3:0]   resp_flags
);

    localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

    state_e        state;
    state_e        next_state;
    logic [CW-1:0] cnt;
    logic [1:0]    grant;
    logic          cur_id;
    logic          accept;
    logic          capture;
    logic          resp_hs;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .valid  ({req1_valid, req0_valid}),
        .accept (accept),
        .id     (req1_ready),
        .grant  (grant)
    );

    assign accept  = req0_ready | req1_ready;
    assign capture = (state == EXEC) && (cnt == CW'(LAT));
    assign resp_hs = resp_valid && resp_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: accept -> execute for LAT cycles -> respond -> idle
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept)  next_state = EXEC;
            EXEC:    if (capture) next_state = RESP;
            RESP:    if (resp_hs) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Readys only in IDLE and only for the arbiter's winner
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == IDLE) begin
            req0_ready = grant[0];
            req1_ready = grant[1];
        end
    end

    // Latch the winner's operands; they drive the datapath until the next accept
    always_ff @(posedge clk) begin
        if (!reset) begin
            dp_a   <= '0;
            dp_b   <= '0;
            dp_op  <= '0;
            cur_id <= 1'b0;
        end else if (accept) begin
            dp_a   <= req1_ready ? req1_a  : req0_a;
            dp_b   <= req1_ready ? req1_b  : req0_b;
            dp_op  <= req1_ready ? req1_op : req0_op;
            cur_id <= req1_ready;
        end
    end

    // Latency counter: cleared on accept, stops counting once the capture fires
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if ((state == EXEC) && !capture) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Response registers: capture once, hold until the consumer takes them
    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_flags  <= '0;
        end else if (capture) begin
            resp_valid         <= 1'b1;
            resp_id            <= cur_id;
            resp_result        <= dp_result;
            resp_flags[FLAG_N] <= dp_N;
            resp_flags[FLAG_Z] <= dp_Z;
            resp_flags[FLAG_C] <= dp_C;
            resp_flags[FLAG_V] <= dp_V;
        end else if (resp_hs) begin
            resp_valid <= 1'b0;
        end
    end

endmodule
